gpio_in: RTL and testbench
==========================

GPIO_IN -- requirements
Module: gpio_in

Interface
REQ-001 Parameter MXLEN, default 32, data/address width of the core-side bus.
REQ-002 Parameter BASE_ADDR, default 32'h0000_2000, 16-byte-aligned base of the register window.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, range 2..65535, consecutive cycles a new pin level must hold before it is accepted.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 in_ja2  input  4  raw asynchronous pin levels.
REQ-007 addr  input  MXLEN  byte address from core (ALU result).
REQ-008 load  input  1  core read strobe.
REQ-009 store  input  1  core write strobe.
REQ-010 w_data  input  MXLEN  write data.
REQ-011 r_data  output  MXLEN  read data, combinational.
REQ-012 irq  output  1  level interrupt request to the trap handler.

Function
REQ-013 Window hit SHALL be addr[MXLEN-1:4] == BASE_ADDR[MXLEN-1:4]; register selected by addr[3:2]; addr[1:0] ignored.
REQ-014 Map: 0 DATA (RO, [3:0] debounced levels); 1 RISE (W1C, [3:0] pending rising edges); 2 FALL (W1C, [3:0] pending falling edges); 3 IEN (RW, [3:0] rise enables, [7:4] fall enables).
REQ-015 r_data SHALL be the selected register zero-extended when load and hit; otherwise 0, including writes to DATA being ignored.
REQ-016 Each pin SHALL pass a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-017 Per pin, a counter of width clog2(DEBOUNCE_CYCLES) SHALL clear on any cycle where sync2 == stable.
REQ-018 While sync2 != stable the counter SHALL increment; on the edge where it equals DEBOUNCE_CYCLES-1 and mismatch persists, stable <= sync2 and counter <= 0.
REQ-019 A clean pin step SHALL change stable exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling the new level; a glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL leave stable and pending flags unchanged.
REQ-020 Counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-021 A stable 0->1 transition SHALL set RISE[i]; 1->0 SHALL set FALL[i], in the same edge stable changes.
REQ-022 Write (store and hit) to RISE/FALL: pend <= (pend & ~w_data[3:0]) | new_edge; a simultaneous new edge SHALL win over the clear.
REQ-023 Write to IEN SHALL load w_data[7:0]; upper bits read 0.
REQ-024 irq SHALL be |((RISE & IEN[3:0]) | (FALL & IEN[7:4])), combinational from registers, so it rises the cycle after the setting edge's register update and drops the cycle after the clearing write.
REQ-025 load and store asserted together SHALL return pre-write contents on r_data and apply the write at the edge.
REQ-026 Pins are independent; simultaneous changes on several pins SHALL be handled per pin without interaction.

Reset
REQ-027 RST low SHALL immediately clear sync1, sync2, stable, counters, RISE, FALL, IEN; r_data 0 when not reading; irq 0.
REQ-028 Reset asserted mid-debounce SHALL discard the count; after release a pin held high SHALL be accepted as a rising edge after 2+DEBOUNCE_CYCLES edges.
REQ-029 No register SHALL depend on the reset being synchronized inside this block; release synchronization is the top level's responsibility.

Verification (DEBOUNCE_CYCLES=4, BASE_ADDR=0x2000)
REQ-030 in_ja2 0->4'b0001 held -> DATA=0x1 at edge 6, RISE=0x1, FALL=0x0; read 0x2000 returns 0x1.
REQ-031 in_ja2[1] high for 3 cycles then low -> DATA, RISE, FALL stay 0x0; counter returns to 0.
REQ-032 IEN=0x10, pin0 rise then fall -> irq stays 0 after rise, goes 1 after fall; store 0x1 to 0x2008 -> irq 0 next cycle.
REQ-033 Store 0x1 to 0x2004 on the same edge RISE[0] sets -> RISE[0] remains 1.
REQ-034 Pin2 held high, RST pulsed low at debounce count 2 -> all registers 0 asynchronously; DATA=0x4 six edges after release.
REQ-035 Read 0x2010 or 0x1FFC -> r_data=0; store to 0x2000 -> DATA unchanged.

Source files
------------

// File: rtl/gpio_in.sv
// Four-pin debounced GPIO input block with rise/fall pending flags, per-edge
// interrupt enables and a small memory-mapped register window on the core bus.
module gpio_in #(
    parameter int               MXLEN           = 32,
    parameter logic [MXLEN-1:0] BASE_ADDR       = 'h0000_2000,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       in_ja2,
    input  logic [MXLEN-1:0] addr,
    input  logic             load,
    input  logic             store,
    input  logic [MXLEN-1:0] w_data,
    output logic [MXLEN-1:0] r_data,
    output logic             irq
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    fire;
    logic [3:0]    rise_evt;
    logic [3:0]    fall_evt;
    logic [3:0]    rise_q;
    logic [3:0]    fall_q;
    logic [7:0]    ien_q;
    logic [CW-1:0] cnt [4];
    logic          hit;
    logic [1:0]    sel;
    logic          wr;
    logic          unused_bits;

    assign hit = (addr[MXLEN-1:4] == BASE_ADDR[MXLEN-1:4]);
    assign sel = addr[3:2];
    assign wr  = store && hit;

    // Byte offset and the upper write-data bits carry no meaning here.
    assign unused_bits = ^{addr[1:0], w_data[MXLEN-1:8]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_ja2;
            sync2 <= sync1;
        end
    end

    // A pin is accepted only once its new level survives the whole count window.
    always_comb begin
        fire = '0;
        for (int i = 0; i < 4; i++) begin
            fire[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign rise_evt = fire & sync2;
    assign fall_evt = fire & ~sync2;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // New edges are OR-ed in after the W1C mask so they are never lost.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rise_q <= '0;
            fall_q <= '0;
            ien_q  <= '0;
        end else begin
            rise_q <= ((wr && sel == 2'd1) ? (rise_q & ~w_data[3:0]) : rise_q) | rise_evt;
            fall_q <= ((wr && sel == 2'd2) ? (fall_q & ~w_data[3:0]) : fall_q) | fall_evt;
            if (wr && sel == 2'd3) begin
                ien_q <= w_data[7:0];
            end
        end
    end

    always_comb begin
        r_data = '0;
        if (load && hit) begin
            case (sel)
                2'd0:    r_data[3:0] = stable;
                2'd1:    r_data[3:0] = rise_q;
                2'd2:    r_data[3:0] = fall_q;
                default: r_data[7:0] = ien_q;
            endcase
        end
    end

    assign irq = |((rise_q & ien_q[3:0]) | (fall_q & ien_q[7:4]));

endmodule

// File: tb/tb_gpio_in.sv
// Directed bench for gpio_in with a 4-cycle debounce window at base 0x2000;
// every expected value below is hand-derived from the register behaviour.
module tb_gpio_in;

    logic        CLK;
    logic        RST;
    logic [3:0]  in_ja2;
    logic [31:0] addr;
    logic        load;
    logic        store;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        irq;

    int vectorCount = 0;
    int missCount   = 0;

    localparam logic [31:0] A_DATA = 32'h2000;
    localparam logic [31:0] A_RISE = 32'h2004;
    localparam logic [31:0] A_FALL = 32'h2008;
    localparam logic [31:0] A_IEN  = 32'h200C;

    gpio_in #(
        .MXLEN(32),
        .BASE_ADDR(32'h0000_2000),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .in_ja2(in_ja2),
        .addr(addr),
        .load(load),
        .store(store),
        .w_data(w_data),
        .r_data(r_data),
        .irq(irq)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One combinational read, taking 1 time unit inside the low clock phase.
    task automatic checkReg(input string tag, input logic [31:0] a, input logic [31:0] expected);
        addr = a;
        load = 1'b1;
        #1;
        checkOutput(tag, r_data, expected);
        load = 1'b0;
    endtask

    // Bus write held across exactly one rising edge, returning on the next falling edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        w_data = d;
        store  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        store  = 1'b0;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST    = 1'b0;
        in_ja2 = 4'b0000;
        addr   = 32'h0;
        load   = 1'b0;
        store  = 1'b0;
        w_data = 32'h0;

        @(negedge CLK);
        addr = A_DATA;
        #1;
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_rdata_noload", r_data, 32'h0);
        checkReg("rst_data", A_DATA, 32'h0);
        checkReg("rst_ien", A_IEN, 32'h0);

        @(negedge CLK);
        RST    = 1'b1;
        in_ja2 = 4'b0001;
        waitEdges(5);
        checkReg("step_data_edge5", A_DATA, 32'h0);
        waitEdges(1);
        checkReg("step_data_edge6", A_DATA, 32'h1);
        checkReg("step_rise", A_RISE, 32'h1);
        checkReg("step_fall", A_FALL, 32'h0);

        // Pin 1 glitch: three cycles high never reaches the acceptance count.
        in_ja2 = 4'b0011;
        waitEdges(3);
        in_ja2 = 4'b0001;
        waitEdges(10);
        checkReg("glitch_data", A_DATA, 32'h1);
        checkReg("glitch_rise", A_RISE, 32'h1);
        checkReg("glitch_fall", A_FALL, 32'h0);

        applyStimulus(A_RISE, 32'h1);
        checkReg("w1c_rise", A_RISE, 32'h0);

        in_ja2 = 4'b0000;
        waitEdges(6);
        checkReg("fall0_data", A_DATA, 32'h0);
        checkReg("fall0_fall", A_FALL, 32'h1);
        applyStimulus(A_FALL, 32'h1);
        checkReg("w1c_fall", A_FALL, 32'h0);
        applyStimulus(A_IEN, 32'h10);
        checkReg("ien_write", A_IEN, 32'h10);

        in_ja2 = 4'b0001;
        waitEdges(6);
        checkReg("irq_rise_flag", A_RISE, 32'h1);
        checkOutput("irq_after_rise", {31'b0, irq}, 32'h0);
        in_ja2 = 4'b0000;
        waitEdges(5);
        checkOutput("irq_pre_fall", {31'b0, irq}, 32'h0);
        waitEdges(1);
        checkOutput("irq_after_fall", {31'b0, irq}, 32'h1);
        checkReg("irq_fall_flag", A_FALL, 32'h1);
        applyStimulus(A_FALL, 32'h1);
        checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
        applyStimulus(A_RISE, 32'h1);
        checkReg("rise_cleared", A_RISE, 32'h0);

        // Clear write lands on the same edge that sets RISE[0].
        in_ja2 = 4'b0001;
        waitEdges(5);
        checkReg("race_rise_pre", A_RISE, 32'h0);
        addr   = A_RISE;
        w_data = 32'h1;
        store  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        store  = 1'b0;
        checkReg("race_rise_wins", A_RISE, 32'h1);
        checkReg("race_data", A_DATA, 32'h1);

        addr   = A_RISE;
        w_data = 32'h1;
        load   = 1'b1;
        store  = 1'b1;
        #1;
        checkOutput("rw_pre_contents", r_data, 32'h1);
        @(posedge CLK);
        @(negedge CLK);
        load   = 1'b0;
        store  = 1'b0;
        checkReg("rw_post_write", A_RISE, 32'h0);

        // Reset pulse while pin 2 is two counts into its window.
        applyStimulus(A_IEN, 32'hA5);
        in_ja2 = 4'b0100;
        waitEdges(4);
        RST = 1'b0;
        #1;
        checkOutput("async_irq", {31'b0, irq}, 32'h0);
        checkReg("async_data", A_DATA, 32'h0);
        @(negedge CLK);
        checkReg("rst_pulse_ien", A_IEN, 32'h0);
        checkReg("rst_pulse_rise", A_RISE, 32'h0);
        checkReg("rst_pulse_fall", A_FALL, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        waitEdges(5);
        checkReg("rel_data_edge5", A_DATA, 32'h0);
        waitEdges(1);
        checkReg("rel_data_edge6", A_DATA, 32'h4);
        checkReg("rel_rise", A_RISE, 32'h4);

        applyStimulus(A_IEN, 32'hFFFF_FFFF);
        checkReg("ien_upper_zero", A_IEN, 32'hFF);
        checkReg("miss_above", 32'h2010, 32'h0);
        checkReg("miss_below", 32'h1FFC, 32'h0);
        checkReg("byte_offset", 32'h2003, 32'h4);
        checkOutput("irq_ien_all", {31'b0, irq}, 32'h1);
        @(negedge CLK);
        applyStimulus(A_DATA, 32'h0);
        checkReg("data_ro", A_DATA, 32'h4);
        addr = A_DATA;
        #1;
        checkOutput("noload_zero", r_data, 32'h0);

        // Pins 1 and 3 rise while pin 2 falls on the same cycle.
        in_ja2 = 4'b1010;
        waitEdges(6);
        checkReg("multi_data", A_DATA, 32'hA);
        checkReg("multi_rise", A_RISE, 32'hE);
        checkReg("multi_fall", A_FALL, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
